pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with stall, bubble, flush and kill.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - upstream handshake (in_ready is combinational)
//   in_data/in_ctrl      - upstream payload and control
//   stall                - blocks the output transfer
//   bubble               - load a zero-control entry instead of accepting input
//   flush                - discard both held entries
//   kill                 - clear KILL_MASK bits of the held main control
//   out_valid/out_ready  - downstream handshake
//   out_data/out_ctrl    - main entry payload and control (registered)
//   occupancy            - number of held entries, 0..2 (registered)
module pipe_stage_reg #(
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             CTRL_W    = 24,
  parameter logic [CTRL_W-1:0]       KILL_MASK = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              bubble,
  input  logic              flush,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [1:0]        occ_q,        occ_d;

  logic in_fire;
  logic out_fire;
  logic main_load;

  // Skid occupied means no room; bubble/flush/reset also refuse input.
  assign in_ready  = ~skid_valid_q & ~bubble & ~flush & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid_q & out_ready & ~stall;
  assign main_load = ~main_valid_q | out_fire;

  // Next-state for both entries.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      // Data is left untouched; only valids and visible control are cleared.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else if (bubble) begin
        // Bubble keeps the old payload, only control is zeroed.
        main_valid_d = 1'b1;
        main_ctrl_d  = '0;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      // Main is holding: input goes to skid, kill trims main control only.
      if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_ctrl_d  = in_ctrl;
      end
      if (kill) begin
        main_ctrl_d = main_ctrl_q & ~KILL_MASK;
      end
    end

    occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      occ_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      occ_q        <= occ_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = occ_q;

endmodule
